// File: rtl/rtl_settings_pkg.sv
// Shared types for the burst compare engine and its neighbours.
package rtl_settings_pkg;

    // Expected-pattern generators selectable per read burst.
    typedef enum logic [1:0] {
        CMP_FIXED = 2'd0,
        CMP_INC   = 2'd1,
        CMP_ADDR  = 2'd2,
        CMP_INV   = 2'd3
    } cmp_mode_t;

endpackage

// File: rtl/burst_compare_engine_if.sv
// Descriptor push, read-beat and result signals of the burst compare engine.
interface burst_compare_engine_if #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int BURST_W = 11
);
    import rtl_settings_pkg::*;

    localparam int DATA_B = DATA_W / 8;
    localparam int BIDX_W = $clog2(DATA_B);

    // Descriptor push from the transmitter and test control.
    logic                     start_test_i;
    logic                     cmp_en_i;
    logic [ADDR_W-1:0]        cmp_addr_i;
    logic [BURST_W-1:0]       cmp_burstcount_i;
    cmp_mode_t                cmp_mode_i;
    logic [7:0]               cmp_seed_i;
    logic [DATA_B-1:0]        cmp_byteenable_i;
    // Read-back beats from the memory.
    logic                     readdatavalid_i;
    logic [DATA_W-1:0]        readdata_i;
    // Results towards the CSR block.
    logic                     queue_full_o;
    logic                     cmp_busy_o;
    logic                     cmp_error_o;
    logic [31:0]              err_cnt_o;
    logic [ADDR_W+BIDX_W-1:0] err_addr_o;
    logic [7:0]               err_data_o;
    logic [7:0]               orig_data_o;
    logic                     ovf_o;
    logic                     unexp_o;

    modport master (
        output start_test_i, cmp_en_i, cmp_addr_i, cmp_burstcount_i, cmp_mode_i,
               cmp_seed_i, cmp_byteenable_i, readdatavalid_i, readdata_i,
        input  queue_full_o, cmp_busy_o, cmp_error_o, err_cnt_o, err_addr_o,
               err_data_o, orig_data_o, ovf_o, unexp_o
    );

    modport slave (
        input  start_test_i, cmp_en_i, cmp_addr_i, cmp_burstcount_i, cmp_mode_i,
               cmp_seed_i, cmp_byteenable_i, readdatavalid_i, readdata_i,
        output queue_full_o, cmp_busy_o, cmp_error_o, err_cnt_o, err_addr_o,
               err_data_o, orig_data_o, ovf_o, unexp_o
    );

endinterface

// File: rtl/burst_compare_engine_fifo.sv
// Generic single-clock FIFO holding outstanding burst descriptors.
// A push while full is accepted only when a pop happens in the same cycle.
module cmp_desc_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o & ~clr_i;
    assign do_push = push_i & (~full_o | do_pop) & ~clr_i;

    // Next pointer and occupancy values.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Descriptor storage.
    always_ff @(posedge clk_i) begin
        // NOTE: storage has no reset; the pointers alone decide which entries are valid.
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/burst_compare_engine.sv
// Checks read-back beats of many outstanding read bursts against generated patterns.
// Two stages: S1 registers beat, expected vector and mask; S2 compares and records results.
module burst_compare_engine
    import rtl_settings_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int BURST_W = 11,
    parameter int DEPTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    burst_compare_engine_if.slave bus
);

    localparam int DATA_B = DATA_W / 8;
    localparam int BIDX_W = $clog2(DATA_B);
    localparam int BA_W   = ADDR_W + BIDX_W;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [BURST_W-1:0] burstcount;
        cmp_mode_t          mode;
        logic [7:0]         seed;
        logic [DATA_B-1:0]  byteenable;
    } cmp_desc_t;

    // Byte address of byte 0 of beat k, wrapping at the byte-address width.
    function automatic logic [BA_W-1:0] beat_base(cmp_desc_t d, logic [BURST_W-1:0] k);
        return (BA_W'(d.addr) + BA_W'(k)) * BA_W'(DATA_B);
    endfunction

    // Expected value of one byte; all arithmetic is modulo 256.
    function automatic logic [7:0] exp_byte(cmp_mode_t mode, logic [7:0] seed,
                                            logic [BURST_W-1:0] k, int unsigned b,
                                            logic [7:0] ba_lo);
        case (mode)
            CMP_FIXED: return seed;
            CMP_INC:   return seed + 8'(k * DATA_B) + 8'(b);
            CMP_ADDR:  return ba_lo ^ seed;
            default:   return (k[0] ^ 1'(b)) ? ~seed : seed;
        endcase
    endfunction

    // Full expected beat for beat k of descriptor d.
    function automatic logic [DATA_W-1:0] exp_beat(cmp_desc_t d, logic [BURST_W-1:0] k);
        logic [DATA_W-1:0] v;
        logic [BA_W-1:0]   base;
        base = beat_base(d, k);
        for (int unsigned b = 0; b < DATA_B; b++) begin
            v[b*8 +: 8] = exp_byte(d.mode, d.seed, k, b, 8'(base + BA_W'(b)));
        end
        return v;
    endfunction

    cmp_desc_t                   head, new_desc;
    logic [$bits(cmp_desc_t)-1:0] head_bits;
    logic                        fifo_full, fifo_empty;
    logic [CNT_W-1:0]            fifo_count;
    logic [BURST_W-1:0]          bc_eff;
    logic                        beat_ok, do_pop, clr;

    logic [BURST_W-1:0] k_q, k_d;
    logic               s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0]  s1_data_q, s1_data_d, s1_exp_q, s1_exp_d;
    logic [DATA_B-1:0]  s1_mask_q, s1_mask_d;
    logic [BA_W-1:0]    s1_ba_q, s1_ba_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               err_q, err_d, ovf_q, ovf_d, unexp_q, unexp_d;
    logic [BA_W-1:0]    eaddr_q, eaddr_d;
    logic [7:0]         edata_q, edata_d, orig_q, orig_d;

    logic               hit;
    int unsigned        hit_idx;

    assign clr      = bus.start_test_i;
    assign head     = cmp_desc_t'(head_bits);
    assign new_desc = '{addr: bus.cmp_addr_i, burstcount: bus.cmp_burstcount_i,
                        mode: bus.cmp_mode_i, seed: bus.cmp_seed_i,
                        byteenable: bus.cmp_byteenable_i};
    assign bc_eff   = (head.burstcount == '0) ? BURST_W'(1) : head.burstcount;
    assign beat_ok  = bus.readdatavalid_i & ~fifo_empty & ~clr;
    assign do_pop   = beat_ok & (k_q == bc_eff - BURST_W'(1));

    cmp_desc_fifo #(
        .WIDTH ($bits(cmp_desc_t)),
        .DEPTH (DEPTH)
    ) u_desc_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clr),
        .push_i  (bus.cmp_en_i),
        .pop_i   (do_pop),
        .wdata_i (new_desc),
        .rdata_o (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // S2: lowest enabled byte of the registered beat that differs from its expected value.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 0;
        for (int b = DATA_B - 1; b >= 0; b--) begin
            if (s1_mask_q[b] && (s1_data_q[b*8 +: 8] != s1_exp_q[b*8 +: 8])) begin
                hit     = 1'b1;
                hit_idx = b;
            end
        end
    end

    // Beat counter, S1 load and result updates.
    always_comb begin
        k_d       = k_q;
        s1_vld_d  = 1'b0;
        s1_data_d = bus.readdata_i;
        s1_exp_d  = exp_beat(head, k_q);
        s1_mask_d = head.byteenable;
        s1_ba_d   = beat_base(head, k_q);
        cnt_d     = cnt_q;
        err_d     = err_q;
        eaddr_d   = eaddr_q;
        edata_d   = edata_q;
        orig_d    = orig_q;
        ovf_d     = ovf_q;
        unexp_d   = unexp_q;
        if (clr) begin
            k_d     = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            eaddr_d = '0;
            edata_d = '0;
            orig_d  = '0;
            ovf_d   = 1'b0;
            unexp_d = 1'b0;
        end else begin
            if (beat_ok) begin
                s1_vld_d = 1'b1;
                k_d      = do_pop ? '0 : k_q + BURST_W'(1);
            end
            if (bus.readdatavalid_i && fifo_empty) unexp_d = 1'b1;
            if (bus.cmp_en_i && fifo_full && !do_pop) ovf_d = 1'b1;
            if (s1_vld_q && hit) begin
                if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
                if (!err_q) begin
                    err_d   = 1'b1;
                    eaddr_d = s1_ba_q + BA_W'(hit_idx);
                    edata_d = s1_data_q[hit_idx*8 +: 8];
                    orig_d  = s1_exp_q[hit_idx*8 +: 8];
                end
            end
        end
    end

    // Control and result registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            k_q      <= '0;
            s1_vld_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            eaddr_q  <= '0;
            edata_q  <= '0;
            orig_q   <= '0;
            ovf_q    <= 1'b0;
            unexp_q  <= 1'b0;
        end else begin
            k_q      <= k_d;
            s1_vld_q <= s1_vld_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            eaddr_q  <= eaddr_d;
            edata_q  <= edata_d;
            orig_q   <= orig_d;
            ovf_q    <= ovf_d;
            unexp_q  <= unexp_d;
        end
    end

    // S1 payload; only meaningful while s1_vld_q is set.
    always_ff @(posedge clk_i) begin
        s1_data_q <= s1_data_d;
        s1_exp_q  <= s1_exp_d;
        s1_mask_q <= s1_mask_d;
        s1_ba_q   <= s1_ba_d;
    end

    assign bus.queue_full_o = fifo_full;
    assign bus.cmp_busy_o   = (fifo_count != '0) | s1_vld_q;
    assign bus.cmp_error_o  = err_q;
    assign bus.err_cnt_o    = cnt_q;
    assign bus.err_addr_o   = eaddr_q;
    assign bus.err_data_o   = edata_q;
    assign bus.orig_data_o  = orig_q;
    assign bus.ovf_o        = ovf_q;
    assign bus.unexp_o      = unexp_q;

endmodule

// File: tb/tb_burst_compare_engine.sv
// Bench for burst_compare_engine: table of single-beat vectors, hand-written
// multi-cycle sequences and a randomized phase, all checked every cycle against
// a queue-based reference model.
module tb_burst_compare_engine;
    import rtl_settings_pkg::*;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 32;
    localparam int BURST_W = 11;
    localparam int DEPTH   = 4;
    localparam int BA_W    = 35;
    localparam longint unsigned BA_MASK = (64'd1 << BA_W) - 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    burst_compare_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

    burst_compare_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .DEPTH(DEPTH)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        longint unsigned addr;
        int              bc;
        int              mode;
        int              seed;
        int              be;
    } mdesc_t;

    typedef struct {
        int              mode;
        int              seed;
        longint unsigned addr;
        int              be;
        logic [63:0]     data;
        bit              err;
        longint unsigned eaddr;
        int              ed;
        int              od;
    } vec_t;

    // Reference model state
    mdesc_t          mq[$];
    int              mk;
    bit              m_s1v, m_s1_mis;
    longint unsigned m_s1_addr;
    int              m_s1_ed, m_s1_od;
    longint unsigned m_cnt, m_eaddr;
    bit              m_err, m_ovf, m_unexp;
    int              m_ed, m_od;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic mdesc_t mk_desc(longint unsigned a, int bc, int mode, int seed, int be);
        mdesc_t d;
        d.addr = a; d.bc = bc; d.mode = mode; d.seed = seed; d.be = be;
        return d;
    endfunction

    function automatic longint unsigned ba_of(mdesc_t d, int k, int b);
        return ((d.addr + longint'(k)) * 8 + longint'(b)) & BA_MASK;
    endfunction

    function automatic int exp_byte(mdesc_t d, int k, int b);
        case (d.mode)
            0:       return d.seed;
            1:       return (d.seed + k * 8 + b) % 256;
            2:       return int'(ba_of(d, k, b) % 256) ^ d.seed;
            default: return ((k + b) % 2 == 0) ? d.seed : (~d.seed & 255);
        endcase
    endfunction

    function automatic logic [63:0] exp_beat(mdesc_t d, int k);
        logic [63:0] v;
        for (int b = 0; b < 8; b++) v[b*8 +: 8] = 8'(exp_byte(d, k, b));
        return v;
    endfunction

    task automatic model_clear();
        mq.delete();
        mk = 0; m_s1v = 0; m_s1_mis = 0; m_s1_addr = 0; m_s1_ed = 0; m_s1_od = 0;
        m_cnt = 0; m_err = 0; m_eaddr = 0; m_ed = 0; m_od = 0; m_ovf = 0; m_unexp = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int          size0;
        bit          popped;
        mdesc_t      d;
        logic [63:0] rd;
        int          act, e;
        if (bus.start_test_i) begin
            model_clear();
            return;
        end
        if (m_s1v && m_s1_mis) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (!m_err) begin
                m_err = 1; m_eaddr = m_s1_addr; m_ed = m_s1_ed; m_od = m_s1_od;
            end
        end
        size0 = mq.size(); popped = 0; m_s1v = 0;
        if (bus.readdatavalid_i) begin
            if (size0 == 0) m_unexp = 1;
            else begin
                d = mq[0]; rd = bus.readdata_i;
                m_s1v = 1; m_s1_mis = 0;
                for (int b = 0; b < 8; b++) begin
                    act = int'(rd[b*8 +: 8]);
                    e   = exp_byte(d, mk, b);
                    if (((d.be >> b) & 1) == 1 && act != e && !m_s1_mis) begin
                        m_s1_mis = 1; m_s1_addr = ba_of(d, mk, b); m_s1_ed = act; m_s1_od = e;
                    end
                end
                mk++;
                if (mk >= ((d.bc == 0) ? 1 : d.bc)) begin
                    void'(mq.pop_front()); mk = 0; popped = 1;
                end
            end
        end
        if (bus.cmp_en_i) begin
            if (size0 == DEPTH && !popped) m_ovf = 1;
            else mq.push_back(mk_desc(bus.cmp_addr_i, int'(bus.cmp_burstcount_i),
                                      int'(bus.cmp_mode_i), int'(bus.cmp_seed_i),
                                      int'(bus.cmp_byteenable_i)));
        end
    endtask

    task automatic compare_all();
        check("queue_full", bus.queue_full_o, 64'(mq.size() == DEPTH));
        check("busy",       bus.cmp_busy_o,   64'(mq.size() != 0 || m_s1v));
        check("error",      bus.cmp_error_o,  64'(m_err));
        check("err_cnt",    bus.err_cnt_o,    m_cnt);
        check("err_addr",   bus.err_addr_o,   m_eaddr);
        check("err_data",   bus.err_data_o,   64'(m_ed));
        check("orig_data",  bus.orig_data_o,  64'(m_od));
        check("ovf",        bus.ovf_o,        64'(m_ovf));
        check("unexp",      bus.unexp_o,      64'(m_unexp));
    endtask

    task automatic clr_in();
        bus.start_test_i = 0; bus.cmp_en_i = 0; bus.cmp_addr_i = '0;
        bus.cmp_burstcount_i = '0; bus.cmp_mode_i = CMP_FIXED; bus.cmp_seed_i = '0;
        bus.cmp_byteenable_i = '0; bus.readdatavalid_i = 0; bus.readdata_i = '0;
    endtask

    task automatic set_push(mdesc_t d);
        bus.cmp_en_i = 1; bus.cmp_addr_i = 32'(d.addr); bus.cmp_burstcount_i = 11'(d.bc);
        bus.cmp_mode_i = cmp_mode_t'(2'(d.mode)); bus.cmp_seed_i = 8'(d.seed);
        bus.cmp_byteenable_i = 8'(d.be);
    endtask

    task automatic set_beat(logic [63:0] data);
        bus.readdatavalid_i = 1; bus.readdata_i = data;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    task automatic idle(int n);
        clr_in();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic start_test();
        clr_in(); bus.start_test_i = 1; cycle(); clr_in();
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic async_reset();
        #2;
        rst_i = 1'b0;
        #1;
        check("rst_full",  bus.queue_full_o, 0);
        check("rst_busy",  bus.cmp_busy_o,   0);
        check("rst_error", bus.cmp_error_o,  0);
        check("rst_cnt",   bus.err_cnt_o,    0);
        check("rst_addr",  bus.err_addr_o,   0);
        check("rst_edata", bus.err_data_o,   0);
        check("rst_orig",  bus.orig_data_o,  0);
        check("rst_ovf",   bus.ovf_o,        0);
        check("rst_unexp", bus.unexp_o,      0);
        model_clear();
        clr_in();
        @(posedge clk_i);
        #3 rst_i = 1'b1;
    endtask

    vec_t        vt[11];
    mdesc_t      d;
    logic [63:0] data;

    initial begin
        vt[0]  = '{mode: 0, seed: 'hA5, addr: 'h10, be: 'hFF, data: 64'hA5A5A5A5A5A5A5A5, err: 0, eaddr: 0, ed: 0, od: 0};
        vt[1]  = '{mode: 1, seed: 'h00, addr: 'h10, be: 'hFF, data: 64'h0706050403020100, err: 0, eaddr: 0, ed: 0, od: 0};
        vt[2]  = '{mode: 1, seed: 'h00, addr: 'h10, be: 'hFF, data: 64'h0706050403FF0100, err: 1, eaddr: 'h82, ed: 'hFF, od: 'h02};
        vt[3]  = '{mode: 2, seed: 'h00, addr: 'h10, be: 'hFF, data: 64'h8786008483828180, err: 1, eaddr: 'h85, ed: 'h00, od: 'h85};
        vt[4]  = '{mode: 2, seed: 'hFF, addr: 'h03, be: 'hFF, data: 64'hE0E1E2E3E4E5E600, err: 1, eaddr: 'h18, ed: 'h00, od: 'hE7};
        vt[5]  = '{mode: 3, seed: 'h5A, addr: 'h20, be: 'hFF, data: 64'hA55AA55AA55AA55A, err: 0, eaddr: 0, ed: 0, od: 0};
        vt[6]  = '{mode: 3, seed: 'h5A, addr: 'h20, be: 'h7F, data: 64'h005AA55AA55AA55A, err: 0, eaddr: 0, ed: 0, od: 0};
        vt[7]  = '{mode: 3, seed: 'h5A, addr: 'h20, be: 'h80, data: 64'h005AA55AA55AA55A, err: 1, eaddr: 'h107, ed: 'h00, od: 'hA5};
        vt[8]  = '{mode: 2, seed: 'h00, addr: 'hFFFFFFFF, be: 'hFF, data: 64'hFFFEFDFCFBFA00F8, err: 1, eaddr: 'h7FFFFFFF9, ed: 'h00, od: 'hF9};
        vt[9]  = '{mode: 0, seed: 'h33, addr: 'h05, be: 'h00, data: 64'h0, err: 0, eaddr: 0, ed: 0, od: 0};
        vt[10] = '{mode: 1, seed: 'hFC, addr: 'h00, be: 'hFF, data: 64'h03020100FFFEFDFC, err: 0, eaddr: 0, ed: 0, od: 0};

        clr_in();
        model_clear();
        async_reset();

        // Table: one single-beat burst per record, results two edges after the beat.
        foreach (vt[i]) begin
            start_test();
            set_push(mk_desc(vt[i].addr, 1, vt[i].mode, vt[i].seed, vt[i].be)); cycle();
            clr_in(); set_beat(vt[i].data); cycle();
            idle(2);
            check($sformatf("vec%0d_cnt", i),   bus.err_cnt_o,   64'(vt[i].err));
            check($sformatf("vec%0d_err", i),   bus.cmp_error_o, 64'(vt[i].err));
            check($sformatf("vec%0d_addr", i),  bus.err_addr_o,  vt[i].eaddr);
            check($sformatf("vec%0d_edata", i), bus.err_data_o,  64'(vt[i].ed));
            check($sformatf("vec%0d_orig", i),  bus.orig_data_o, 64'(vt[i].od));
            check($sformatf("vec%0d_busy", i),  bus.cmp_busy_o,  0);
        end

        // Four-beat FIXED burst, busy drops two edges after the last beat.
        start_test();
        set_push(mk_desc('h10, 4, 0, 'hA5, 'hFF)); cycle();
        for (int i = 0; i < 4; i++) begin clr_in(); set_beat({8{8'hA5}}); cycle(); end
        check("fixed_busy_1", bus.cmp_busy_o, 1);
        idle(1);
        check("fixed_busy_2", bus.cmp_busy_o, 0);
        check("fixed_cnt",    bus.err_cnt_o,  0);

        // INC burst of two beats, byte 3 of beat 1 wrong.
        start_test();
        set_push(mk_desc('h10, 2, 1, 'h00, 'hFF)); cycle();
        clr_in(); set_beat(64'h0706050403020100); cycle();
        clr_in(); set_beat(64'h0F0E0D0C000A0908); cycle();
        idle(2);
        check("inc_addr",  bus.err_addr_o,  'h8B);
        check("inc_edata", bus.err_data_o,  'h00);
        check("inc_orig",  bus.orig_data_o, 'h0B);
        check("inc_cnt",   bus.err_cnt_o,   1);

        // Five pushes into a four-deep queue, then the four kept bursts.
        start_test();
        for (int i = 0; i < 5; i++) begin
            clr_in(); set_push(mk_desc(i, 1, 0, 'h10 + i, 'hFF)); cycle();
            if (i == 3) check("ovf_full_after_4", bus.queue_full_o, 1);
        end
        check("ovf_flag", bus.ovf_o, 1);
        for (int i = 0; i < 4; i++) begin clr_in(); set_beat({8{8'(8'h10 + i)}}); cycle(); end
        idle(2);
        check("ovf_cnt",  bus.err_cnt_o,  0);
        check("ovf_busy", bus.cmp_busy_o, 0);

        // Beat with an empty queue, then a masked-off corrupt byte.
        start_test();
        set_beat(64'h1234); cycle();
        idle(2);
        check("unexp_flag", bus.unexp_o,   1);
        check("unexp_cnt",  bus.err_cnt_o, 0);
        clr_in(); set_push(mk_desc(0, 1, 0, 'h3C, 'h0F)); cycle();
        clr_in(); set_beat(64'h3C003C3C3C3C3C3C); cycle();
        idle(2);
        check("mask_err", bus.cmp_error_o, 0);

        // Two mismatching bursts back-to-back; first capture holds, then clear.
        start_test();
        set_push(mk_desc('h40, 2, 0, 'h11, 'hFF)); cycle();
        clr_in(); set_push(mk_desc('h80, 1, 0, 'h22, 'hFF)); cycle();
        clr_in(); set_beat({8{8'h11}}); cycle();
        clr_in(); set_beat(64'h111111FF11111111); cycle();
        clr_in(); set_beat(64'h2222222222222200); cycle();
        idle(2);
        check("two_cnt",   bus.err_cnt_o,   2);
        check("two_addr",  bus.err_addr_o,  'h20C);
        check("two_edata", bus.err_data_o,  'hFF);
        check("two_orig",  bus.orig_data_o, 'h11);
        start_test();
        check("clr_cnt",  bus.err_cnt_o,   0);
        check("clr_err",  bus.cmp_error_o, 0);
        check("clr_addr", bus.err_addr_o,  0);

        // Push and pop in the same cycle while full.
        for (int i = 0; i < 4; i++) begin clr_in(); set_push(mk_desc(i, 1, 0, 'h50 + i, 'hFF)); cycle(); end
        check("pp_full_before", bus.queue_full_o, 1);
        clr_in(); set_push(mk_desc(4, 1, 0, 'h54, 'hFF)); set_beat({8{8'h50}}); cycle();
        check("pp_full_after", bus.queue_full_o, 1);
        check("pp_ovf",        bus.ovf_o,        0);
        for (int i = 1; i < 5; i++) begin clr_in(); set_beat({8{8'(8'h50 + i)}}); cycle(); end
        idle(2);
        check("pp_cnt",  bus.err_cnt_o,  0);
        check("pp_busy", bus.cmp_busy_o, 0);

        // Reset in the middle of a burst with errors already counted.
        start_test();
        set_push(mk_desc(0, 4, 1, 0, 'hFF)); cycle();
        for (int i = 0; i < 2; i++) begin clr_in(); set_beat(64'h0); cycle(); end
        idle(1);
        check("mid_cnt", bus.err_cnt_o, 2);
        async_reset();
        clr_in(); set_beat(64'h0); cycle();
        check("post_rst_unexp", bus.unexp_o, 1);
        idle(1);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            clr_in();
            if ($urandom_range(0, 299) == 0) bus.start_test_i = 1;
            if ($urandom_range(0, 99) < 30) begin
                d = mk_desc(($urandom_range(0, 3) == 0) ? (64'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom,
                            $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 255),
                            ($urandom_range(0, 1) == 0) ? 'hFF : $urandom_range(0, 255));
                set_push(d);
            end
            if (mq.size() > 0 ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 5)) begin
                data = (mq.size() > 0) ? exp_beat(mq[0], mk) : {$urandom, $urandom};
                if ($urandom_range(0, 99) < 20)
                    data = data ^ (64'($urandom_range(1, 255)) << (8 * $urandom_range(0, 7)));
                set_beat(data);
            end
            cycle();
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
